// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall controller.
// The datapath side (master) reports hazard sources and consumes the register
// enables/flushes; the controller side (slave) does the reverse.
interface pipeline_stall_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  branch_taken;
    logic                  md_start;
    logic                  mem_stall;

    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exmem_flush;
    logic                  md_busy;
    logic                  md_done;

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, md_start, mem_stall,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, md_busy, md_done
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, md_start, mem_stall,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, md_busy, md_done
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard/stall controller for the 5-stage MIPS pipeline.
// Drives enables/flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers,
// resolving load-use hazards, taken branches, multi-cycle mult/div occupancy
// and data-memory wait states. Priority: reset, mem_stall, MD_WAIT, branch,
// load-use, default.
// Optional: define PIPE_PERF_CNT_EN to add the saturating stall_cycles counter.
module pipeline_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_stall_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Cycle 1 of a mult/div is spent in RUN, so the wait count covers the rest
    // minus the final (count==0) cycle.
    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 2);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    state_t     state, state_nxt;
    logic [7:0] md_cnt, md_cnt_nxt;
    logic       retire, retire_nxt;
    logic       load_use;

    assign load_use = bus.ex_mem_read && (bus.ex_rt != ZERO_REG) &&
                      ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

    // Hazard state: FSM state, MD countdown and the retire guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= 8'd0;
            retire <= 1'b0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            retire <= retire_nxt;
        end
    end

    // Next-state logic and register enable/flush decode, all forced low in reset.
    always_comb begin
        state_nxt       = state;
        md_cnt_nxt      = md_cnt;
        retire_nxt      = retire;
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idex_en     = 1'b0;
        bus.exmem_en    = 1'b0;
        bus.memwb_en    = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.md_busy     = 1'b0;
        bus.md_done     = 1'b0;

        if (rst_n) begin
            case (state)
                RUN: begin
                    // A frozen pipe keeps the retiring mult/div and its guard in place.
                    if (!bus.mem_stall) begin
                        retire_nxt = 1'b0;
                        if (bus.md_start && !retire) begin
                            state_nxt  = MD_WAIT;
                            md_cnt_nxt = MD_LOAD;
                        end
                    end
                end
                MD_WAIT: begin
                    // The countdown runs even while memory stalls the pipe.
                    bus.md_busy = 1'b1;
                    if (md_cnt == 8'd0) begin
                        bus.md_done = 1'b1;
                        state_nxt   = RUN;
                        retire_nxt  = 1'b1;
                    end else begin
                        md_cnt_nxt = md_cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase

            if (bus.mem_stall) begin
                // Whole pipe frozen: every enable and flush stays low.
            end else if (state == MD_WAIT) begin
                bus.exmem_en    = 1'b1;
                bus.exmem_flush = 1'b1;
                bus.memwb_en    = 1'b1;
            end else if (bus.branch_taken) begin
                bus.pc_en      = 1'b1;
                bus.ifid_en    = 1'b1;
                bus.idex_en    = 1'b1;
                bus.exmem_en   = 1'b1;
                bus.memwb_en   = 1'b1;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (load_use) begin
                bus.idex_en    = 1'b1;
                bus.exmem_en   = 1'b1;
                bus.memwb_en   = 1'b1;
                bus.idex_flush = 1'b1;
            end else begin
                bus.pc_en    = 1'b1;
                bus.ifid_en  = 1'b1;
                bus.idex_en  = 1'b1;
                bus.exmem_en = 1'b1;
                bus.memwb_en = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
        end else if (!bus.pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, all built from enable/reset flip-flops.
- Resolves load-use hazards, taken-branch squashes, multi-cycle multiply/divide occupancy and data-memory wait states.
- Owns the only sequential hazard state in the core: the MD wait FSM, the MD countdown and the retire flag.

Parameters:
- MD_LATENCY, 32, total EX occupancy in cycles of a mult/div instruction; legal range 2..255.
- REG_ADDR_W, 5, register-specifier width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  REG_ADDR_W  rs of the instruction in ID.
- id_rt  input  REG_ADDR_W  rt of the instruction in ID.
- ex_mem_read  input  1  the instruction in EX is a load.
- ex_rt  input  REG_ADDR_W  destination of the load in EX.
- branch_taken  input  1  branch/jump resolved taken in EX.
- md_start  input  1  the instruction in EX is mult/div.
- mem_stall  input  1  data memory not ready; freezes the whole pipe.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush  output  1 each  synchronous clear of the register (a flush overrides its enable).
- md_busy  output  1  high while in MD_WAIT.
- md_done  output  1  one-cycle pulse on the final MD_WAIT cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, md_cnt=0, retire=0.
  - All enables 0, all flushes 0, md_busy=0, md_done=0, held for the whole time reset is asserted.
- Outputs are combinational from state plus inputs. Registered state is limited to: state, md_cnt (8 bits), retire.
- Decision priority, highest first:
  1. rst_n=0
  2. mem_stall
  3. MD_WAIT
  4. branch_taken
  5. load-use
  6. default.
- mem_stall=1 (any state):
  - All enables 0, all flushes 0.
  - md_cnt still decrements in MD_WAIT.
  - The FSM may still exit MD_WAIT.
- RUN, default: all enables 1, all flushes 0.
- RUN, branch_taken=1:
  - All enables 1; ifid_flush=1, idex_flush=1.
  - Load-use is ignored this cycle.
- RUN, load-use:
  - Condition: ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or ex_rt==id_rt).
  - pc_en=0, ifid_en=0, idex_flush=1; idex_en, exmem_en, memwb_en = 1.
  - Exactly one bubble per load.
- RUN, md_start=1, mem_stall=0, retire=0:
  - Next state MD_WAIT; md_cnt loads MD_LATENCY-2.
  - The outputs this cycle follow the normal RUN rules. This is MD cycle 1.
- MD_WAIT:
  - pc_en, ifid_en, idex_en = 0.
  - exmem_en=1, exmem_flush=1 (a bubble into MEM); memwb_en=1.
  - md_busy=1. branch_taken, load-use and md_start are ignored.
  - md_cnt decrements each cycle.
  - When md_cnt==0: md_done=1, next state RUN, retire set to 1.
  - When mem_stall=1 in MD_WAIT, the mem_stall outputs override these enables/flushes, but the count proceeds.
- retire:
  - Blocks md_start re-acceptance for the mult/div instruction still sitting in EX.
  - Cleared on the first RUN cycle with mem_stall=0; that cycle the instruction advances normally.
- Total EX occupancy of a mult/div with no mem_stall is exactly MD_LATENCY cycles.
- Reset mid-MD_WAIT aborts the operation immediately; no md_done pulse is produced.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: adds output stall_cycles (32 bits).
  - Async reset to 0.
  - Increments on every cycle with rst_n=1 and pc_en=0.
  - Saturates at 0xFFFFFFFF.
- Undefined: no port, no counter logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> all outputs 0 every cycle. Release -> pc_en=1, all flushes 0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Repeat with ex_rt=0 -> no stall.
- Branch and load-use together: branch_taken=1 with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1.
- Mult/div: MD_LATENCY=4, md_start held high -> md_busy high for 3 cycles. md_done pulses on the 3rd. The next cycle pc_en=1, no restart despite md_start=1.
- mem_stall during MD_WAIT: MD_LATENCY=4, mem_stall=1 from the 2nd to the 6th cycle -> md_done still on the 3rd cycle. retire holds until mem_stall drops. md_start is not re-accepted.
- PIPE_PERF_CNT_EN defined: one load-use stall plus one MD_LATENCY=4 op -> stall_cycles=4.
